// File: rtl/usb3_ep_pkg.sv
// Shared constants for the USB3 endpoint router: endpoint modes, select width, FSM encoding.
package usb3_ep_pkg;

    localparam int SEL_W = 4;

    localparam logic [1:0] EP_MODE_CONTROL   = 2'd0;
    localparam logic [1:0] EP_MODE_ISOCH     = 2'd1;
    localparam logic [1:0] EP_MODE_BULK      = 2'd2;
    localparam logic [1:0] EP_MODE_INTERRUPT = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE        = 2'd0,
        ST_COMMIT_WAIT = 2'd1,
        ST_ARM_WAIT    = 2'd2
    } state_t;

endpackage

// File: rtl/usb3_ep_seq.sv
// Per-endpoint sequence-number bank; a clear on an endpoint takes priority over an advance.
module usb3_ep_seq
    import usb3_ep_pkg::*;
#(
    parameter int NUM_EP = 4,
    parameter int SEQ_W  = 5
) (
    input  logic              local_clk,
    input  logic              reset,
    input  logic [SEL_W-1:0]  sel,
    input  logic              adv,
    input  logic [NUM_EP-1:0] clr,
    output logic [SEQ_W-1:0]  num
);

    logic [NUM_EP-1:0][SEQ_W-1:0] cnt;

    always_ff @(posedge local_clk) begin
        if (reset) begin
            cnt <= '0;
        end else begin
            for (int i = 0; i < NUM_EP; i++) begin
                if (clr[i])
                    cnt[i] <= '0;
                else if (adv && sel == SEL_W'(i))
                    cnt[i] <= cnt[i] + SEQ_W'(1);
            end
        end
    end

    always_comb begin
        num = '0;
        for (int i = 0; i < NUM_EP; i++)
            if (sel == SEL_W'(i)) num = cnt[i];
    end

endmodule

// File: rtl/usb3_ep_router.sv
// Endpoint router between the USB3 link buffer interface and per-endpoint buffers,
// with registered endpoint select, commit/arm handshake FSM and ack timeout.
module usb3_ep_router
    import usb3_ep_pkg::*;
#(
    parameter int                  NUM_EP      = 4,
    parameter int                  ADDR_W      = 9,
    parameter int                  DATA_W      = 32,
    parameter int                  LEN_W       = 11,
    parameter int                  SEQ_W       = 5,
    parameter logic [2*NUM_EP-1:0] EP_MODES    = {2'd2, 2'd2, 2'd2, 2'd0},
    parameter logic [NUM_EP-1:0]   EP_IN_MASK  = 4'b0101,
    parameter logic [NUM_EP-1:0]   EP_OUT_MASK = 4'b0011,
    parameter int                  ACK_TIMEOUT = 255
) (
    input  logic                           local_clk,
    input  logic                           reset,
    input  logic [SEL_W-1:0]               sel_endp,
    input  logic                           sel_load,
    output logic [SEL_W-1:0]               cur_endp,
    input  logic [ADDR_W-1:0]              buf_in_addr,
    input  logic [DATA_W-1:0]              buf_in_data,
    input  logic                           buf_in_wren,
    input  logic                           buf_in_commit,
    input  logic [LEN_W-1:0]               buf_in_commit_len,
    output logic                           buf_in_ready,
    output logic                           buf_in_commit_ack,
    input  logic [ADDR_W-1:0]              buf_out_addr,
    input  logic                           buf_out_arm,
    output logic [DATA_W-1:0]              buf_out_q,
    output logic [LEN_W-1:0]               buf_out_len,
    output logic                           buf_out_hasdata,
    output logic                           buf_out_arm_ack,
    output logic [NUM_EP-1:0][ADDR_W-1:0]  ep_buf_in_addr,
    output logic [NUM_EP-1:0][DATA_W-1:0]  ep_buf_in_data,
    output logic [NUM_EP-1:0]              ep_buf_in_wren,
    output logic [NUM_EP-1:0]              ep_buf_in_commit,
    output logic [NUM_EP-1:0][LEN_W-1:0]   ep_buf_in_commit_len,
    input  logic [NUM_EP-1:0]              ep_buf_in_ready,
    input  logic [NUM_EP-1:0]              ep_buf_in_commit_ack,
    output logic [NUM_EP-1:0][ADDR_W-1:0]  ep_buf_out_addr,
    output logic [NUM_EP-1:0]              ep_buf_out_arm,
    input  logic [NUM_EP-1:0][DATA_W-1:0]  ep_buf_out_q,
    input  logic [NUM_EP-1:0][LEN_W-1:0]   ep_buf_out_len,
    input  logic [NUM_EP-1:0]              ep_buf_out_hasdata,
    input  logic [NUM_EP-1:0]              ep_buf_out_arm_ack,
    output logic [1:0]                     endp_mode,
    input  logic                           seq_adv,
    input  logic [NUM_EP-1:0]              seq_clr,
    output logic [SEQ_W-1:0]               seq_num,
    output logic                           busy,
    output logic                           err_undefined,
    output logic                           err_timeout
);

    // Masks widened to the full select range so any 4-bit select indexes safely.
    localparam logic [15:0] IN_M  = 16'(EP_IN_MASK);
    localparam logic [15:0] OUT_M = 16'(EP_OUT_MASK);
    localparam logic [15:0] ANY_M = IN_M | OUT_M;

    state_t            state;
    logic [15:0]       timer;
    logic [LEN_W-1:0]  commit_len_q;
    logic [NUM_EP-1:0] hit;
    logic              in_ok, out_ok, sel_ok;
    logic              cur_cack, cur_aack;

    assign in_ok  = IN_M[cur_endp];
    assign out_ok = OUT_M[cur_endp];
    assign sel_ok = (int'(sel_endp) < NUM_EP) && ANY_M[sel_endp];

    for (genvar i = 0; i < NUM_EP; i++) begin : g_ep
        assign hit[i]                  = (cur_endp == SEL_W'(i));
        assign ep_buf_in_addr[i]       = hit[i] ? buf_in_addr : '0;
        assign ep_buf_in_data[i]       = hit[i] ? buf_in_data : '0;
        assign ep_buf_in_wren[i]       = hit[i] && in_ok && buf_in_wren;
        assign ep_buf_in_commit_len[i] = hit[i] ? commit_len_q : '0;
        assign ep_buf_out_addr[i]      = hit[i] ? buf_out_addr : '0;
    end

    always_comb begin
        buf_in_ready    = 1'b0;
        buf_out_q       = '0;
        buf_out_len     = '0;
        buf_out_hasdata = 1'b0;
        cur_cack        = 1'b0;
        cur_aack        = 1'b0;
        for (int i = 0; i < NUM_EP; i++) begin
            if (hit[i]) begin
                cur_cack = ep_buf_in_commit_ack[i];
                cur_aack = ep_buf_out_arm_ack[i];
                if (in_ok) buf_in_ready = ep_buf_in_ready[i];
                if (out_ok) begin
                    buf_out_q       = ep_buf_out_q[i];
                    buf_out_len     = ep_buf_out_len[i];
                    buf_out_hasdata = ep_buf_out_hasdata[i];
                end
            end
        end
    end

    always_comb begin
        endp_mode = '0;
        for (int i = 0; i < NUM_EP; i++)
            if (hit[i]) endp_mode = EP_MODES[2*i +: 2];
    end

    always_ff @(posedge local_clk) begin
        if (reset) begin
            state             <= ST_IDLE;
            timer             <= '0;
            commit_len_q      <= '0;
            cur_endp          <= '0;
            busy              <= 1'b0;
            err_undefined     <= 1'b0;
            err_timeout       <= 1'b0;
            ep_buf_in_commit  <= '0;
            ep_buf_out_arm    <= '0;
            buf_in_commit_ack <= 1'b0;
            buf_out_arm_ack   <= 1'b0;
        end else begin
            ep_buf_in_commit  <= '0;
            ep_buf_out_arm    <= '0;
            buf_in_commit_ack <= 1'b0;
            buf_out_arm_ack   <= 1'b0;

            if (sel_load) begin
                if (state != ST_IDLE || !sel_ok) err_undefined <= 1'b1;
                else                             cur_endp      <= sel_endp;
            end

            case (state)
                ST_IDLE: begin
                    // Commit has priority; a simultaneous arm is dropped.
                    if (buf_in_commit) begin
                        if (in_ok) begin
                            ep_buf_in_commit <= hit;
                            commit_len_q     <= buf_in_commit_len;
                            timer            <= '0;
                            busy             <= 1'b1;
                            state            <= ST_COMMIT_WAIT;
                        end else begin
                            err_undefined <= 1'b1;
                        end
                    end else if (buf_out_arm) begin
                        if (out_ok) begin
                            ep_buf_out_arm <= hit;
                            timer          <= '0;
                            busy           <= 1'b1;
                            state          <= ST_ARM_WAIT;
                        end else begin
                            err_undefined <= 1'b1;
                        end
                    end
                end
                ST_COMMIT_WAIT, ST_ARM_WAIT: begin
                    if (state == ST_COMMIT_WAIT ? cur_cack : cur_aack) begin
                        buf_in_commit_ack <= (state == ST_COMMIT_WAIT);
                        buf_out_arm_ack   <= (state == ST_ARM_WAIT);
                        busy              <= 1'b0;
                        state             <= ST_IDLE;
                    end else if (timer == 16'(ACK_TIMEOUT - 1)) begin
                        err_timeout <= 1'b1;
                        busy        <= 1'b0;
                        state       <= ST_IDLE;
                    end else begin
                        timer <= timer + 16'd1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    usb3_ep_seq #(
        .NUM_EP (NUM_EP),
        .SEQ_W  (SEQ_W)
    ) u_seq (
        .local_clk (local_clk),
        .reset     (reset),
        .sel       (cur_endp),
        .adv       (seq_adv),
        .clr       (seq_clr),
        .num       (seq_num)
    );

endmodule

// File: tb/tb_usb3_ep_router.sv
// Directed bench for usb3_ep_router: select, datapath steering, commit/arm handshake,
// timeout, sequence wrap/clear and reset during a handshake.
module tb_usb3_ep_router;
    import usb3_ep_pkg::*;

    localparam int NUM_EP = 4, ADDR_W = 9, DATA_W = 32, LEN_W = 11, SEQ_W = 5;

    logic                          local_clk = 1'b0;
    logic                          reset;
    logic [SEL_W-1:0]              sel_endp, cur_endp;
    logic                          sel_load;
    logic [ADDR_W-1:0]             buf_in_addr, buf_out_addr;
    logic [DATA_W-1:0]             buf_in_data, buf_out_q;
    logic                          buf_in_wren, buf_in_commit, buf_in_ready, buf_in_commit_ack;
    logic [LEN_W-1:0]              buf_in_commit_len, buf_out_len;
    logic                          buf_out_arm, buf_out_hasdata, buf_out_arm_ack;
    logic [NUM_EP-1:0][ADDR_W-1:0] ep_buf_in_addr, ep_buf_out_addr;
    logic [NUM_EP-1:0][DATA_W-1:0] ep_buf_in_data, ep_buf_out_q;
    logic [NUM_EP-1:0]             ep_buf_in_wren, ep_buf_in_commit, ep_buf_in_ready, ep_buf_in_commit_ack;
    logic [NUM_EP-1:0][LEN_W-1:0]  ep_buf_in_commit_len, ep_buf_out_len;
    logic [NUM_EP-1:0]             ep_buf_out_arm, ep_buf_out_hasdata, ep_buf_out_arm_ack;
    logic [1:0]                    endp_mode;
    logic                          seq_adv;
    logic [NUM_EP-1:0]             seq_clr;
    logic [SEQ_W-1:0]              seq_num;
    logic                          busy, err_undefined, err_timeout;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 local_clk = ~local_clk;

    usb3_ep_router #(.ACK_TIMEOUT(8)) dut (
        .local_clk(local_clk), .reset(reset),
        .sel_endp(sel_endp), .sel_load(sel_load), .cur_endp(cur_endp),
        .buf_in_addr(buf_in_addr), .buf_in_data(buf_in_data), .buf_in_wren(buf_in_wren),
        .buf_in_commit(buf_in_commit), .buf_in_commit_len(buf_in_commit_len),
        .buf_in_ready(buf_in_ready), .buf_in_commit_ack(buf_in_commit_ack),
        .buf_out_addr(buf_out_addr), .buf_out_arm(buf_out_arm),
        .buf_out_q(buf_out_q), .buf_out_len(buf_out_len),
        .buf_out_hasdata(buf_out_hasdata), .buf_out_arm_ack(buf_out_arm_ack),
        .ep_buf_in_addr(ep_buf_in_addr), .ep_buf_in_data(ep_buf_in_data),
        .ep_buf_in_wren(ep_buf_in_wren), .ep_buf_in_commit(ep_buf_in_commit),
        .ep_buf_in_commit_len(ep_buf_in_commit_len), .ep_buf_in_ready(ep_buf_in_ready),
        .ep_buf_in_commit_ack(ep_buf_in_commit_ack), .ep_buf_out_addr(ep_buf_out_addr),
        .ep_buf_out_arm(ep_buf_out_arm), .ep_buf_out_q(ep_buf_out_q),
        .ep_buf_out_len(ep_buf_out_len), .ep_buf_out_hasdata(ep_buf_out_hasdata),
        .ep_buf_out_arm_ack(ep_buf_out_arm_ack),
        .endp_mode(endp_mode), .seq_adv(seq_adv), .seq_clr(seq_clr), .seq_num(seq_num),
        .busy(busy), .err_undefined(err_undefined), .err_timeout(err_timeout)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge local_clk);
        #1;
    endtask

    task automatic sel(input logic [SEL_W-1:0] e);
        sel_endp = e;
        sel_load = 1'b1;
        tick();
        sel_load = 1'b0;
    endtask

    initial begin
        logic seen_ack;
        reset = 1'b1; sel_endp = '0; sel_load = 1'b0;
        buf_in_addr = '0; buf_in_data = '0; buf_in_wren = 1'b0;
        buf_in_commit = 1'b0; buf_in_commit_len = '0;
        buf_out_addr = '0; buf_out_arm = 1'b0;
        ep_buf_in_ready = '0; ep_buf_in_commit_ack = '0;
        ep_buf_out_q = '0; ep_buf_out_len = '0; ep_buf_out_hasdata = '0; ep_buf_out_arm_ack = '0;
        seq_adv = 1'b0; seq_clr = '0;
        tick(); tick();
        reset = 1'b0;
        tick();

        chk("rst_cur", cur_endp, 0);
        chk("rst_busy", busy, 0);
        chk("rst_erru", err_undefined, 0);
        chk("rst_errt", err_timeout, 0);
        chk("rst_seq", seq_num, 0);
        chk("rst_mode", endp_mode, 0);
        chk("rst_pulses", {ep_buf_in_commit, ep_buf_out_arm, buf_in_commit_ack, buf_out_arm_ack}, 0);

        // Select endpoint 2 (bulk, IN only) and steer a write to it.
        sel(4'd2);
        chk("sel2_cur", cur_endp, 2);
        chk("sel2_mode", endp_mode, 2);
        chk("sel2_erru", err_undefined, 0);
        buf_in_addr = 9'h055; buf_in_data = 32'h1234_5678; buf_in_wren = 1'b1;
        ep_buf_in_ready = 4'b0100;
        #1;
        chk("ep2_wren", ep_buf_in_wren, 4'b0100);
        chk("ep2_addr", ep_buf_in_addr, 64'h055 << 18);
        chk("ep2_data_slice", ep_buf_in_data[2], 32'h1234_5678);
        chk("ep2_data_other", ep_buf_in_data[0], 0);
        chk("ep2_ready", buf_in_ready, 1);
        buf_in_wren = 1'b0;

        // 33 advances on endpoint 2: 31 is reached, then wraps through 0 to 1.
        seq_adv = 1'b1;
        for (int k = 1; k <= 33; k++) begin
            tick();
            if (k == 31) chk("seq_31", seq_num, 31);
        end
        seq_adv = 1'b0;
        chk("seq_wrap", seq_num, 1);
        seq_adv = 1'b1; seq_clr = 4'b0100;
        tick();
        seq_adv = 1'b0; seq_clr = '0;
        chk("seq_clr_wins", seq_num, 0);

        // Out-of-range select keeps cur_endp and flags an error.
        sel(4'd7);
        chk("sel7_cur", cur_endp, 2);
        chk("sel7_erru", err_undefined, 1);

        // Commit on endpoint 0, ack three cycles after the ep pulse.
        sel(4'd0);
        chk("sel0_mode", endp_mode, 0);
        buf_in_commit = 1'b1; buf_in_commit_len = 11'd64;
        tick();
        buf_in_commit = 1'b0; buf_in_commit_len = '0;
        chk("cmt_pulse", ep_buf_in_commit, 4'b0001);
        chk("cmt_len", ep_buf_in_commit_len[0], 64);
        chk("cmt_busy", busy, 1);
        tick();
        chk("cmt_once", ep_buf_in_commit, 0);
        tick(); tick();
        chk("cmt_noack_yet", buf_in_commit_ack, 0);
        ep_buf_in_commit_ack = 4'b0001;
        tick();
        ep_buf_in_commit_ack = '0;
        chk("cmt_ack", buf_in_commit_ack, 1);
        chk("cmt_busy_lo", busy, 0);
        tick();
        chk("cmt_ack_1cyc", buf_in_commit_ack, 0);

        // Commit and arm together: commit wins.
        buf_in_commit = 1'b1; buf_out_arm = 1'b1; buf_in_commit_len = 11'd5;
        tick();
        buf_in_commit = 1'b0; buf_out_arm = 1'b0;
        chk("both_cmt", ep_buf_in_commit, 4'b0001);
        chk("both_arm", ep_buf_out_arm, 0);
        ep_buf_in_commit_ack = 4'b0001;
        tick();
        ep_buf_in_commit_ack = '0;
        chk("both_ack", buf_in_commit_ack, 1);

        // Endpoint 1 is OUT only: writes blocked, reads visible.
        sel(4'd1);
        buf_in_wren = 1'b1; ep_buf_in_ready = 4'b1111;
        ep_buf_out_q[1] = 32'hDEAD_BEEF; ep_buf_out_hasdata = 4'b0010;
        #1;
        chk("ep1_wren_blk", ep_buf_in_wren, 0);
        chk("ep1_ready", buf_in_ready, 0);
        chk("ep1_q", buf_out_q, 32'hDEAD_BEEF);
        chk("ep1_hasdata", buf_out_hasdata, 1);
        buf_in_wren = 1'b0; ep_buf_in_ready = '0;

        // Arm on endpoint 1 with no ack: timeout 8 cycles after the pulse.
        buf_out_arm = 1'b1;
        tick();
        buf_out_arm = 1'b0;
        chk("arm_pulse", ep_buf_out_arm, 4'b0010);
        chk("arm_busy", busy, 1);
        seen_ack = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (buf_out_arm_ack) seen_ack = 1'b1;
            if (k == 7) chk("tmo_early", err_timeout, 0);
        end
        chk("tmo_set", err_timeout, 1);
        chk("tmo_busy_lo", busy, 0);
        chk("tmo_no_ack", seen_ack, 0);

        // Reset mid-handshake, then a late ack is ignored.
        sel(4'd0);
        buf_in_commit = 1'b1; buf_in_commit_len = 11'd9;
        tick();
        buf_in_commit = 1'b0;
        chk("mid_busy", busy, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_errs", {err_undefined, err_timeout}, 0);
        ep_buf_in_commit_ack = 4'b0001;
        tick();
        ep_buf_in_commit_ack = '0;
        chk("late_ack", buf_in_commit_ack, 0);
        chk("late_busy", busy, 0);

        // Commit to an endpoint outside the IN mask.
        sel(4'd1);
        buf_in_commit = 1'b1;
        tick();
        buf_in_commit = 1'b0;
        chk("bad_cmt_erru", err_undefined, 1);
        chk("bad_cmt_busy", busy, 0);
        chk("bad_cmt_pulse", ep_buf_in_commit, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
